// File: rtl/fb_pkg.sv
// Shared frame-buffer layout constants and types.
// Used by both the write side and the scan-out address path.
package fb_pkg;

  localparam int H_RES          = 640;
  localparam int V_RES          = 480;
  localparam int WORDS_PER_LINE = 214;

  localparam int PIX_W  = 9;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 27;

  localparam int SLOT0_LSB = 0;
  localparam int SLOT1_LSB = 9;
  localparam int SLOT2_LSB = 18;

  localparam int R_MSB = 8;
  localparam int R_LSB = 6;
  localparam int G_MSB = 5;
  localparam int G_LSB = 3;
  localparam int B_MSB = 2;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } fb_state_e;

  function automatic logic [DATA_W-1:0] slot_place(
    input logic [PIX_W-1:0] rgb,
    input logic [1:0]       slot
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (slot)
      2'd1:    v[SLOT1_LSB +: PIX_W] = rgb;
      2'd2:    v[SLOT2_LSB +: PIX_W] = rgb;
      default: v[SLOT0_LSB +: PIX_W] = rgb;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] slot_onehot(
    input logic [1:0] slot
  );
    logic [2:0] v;
    case (slot)
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b001;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel (x, y) to frame-buffer word address and slot.
// Shared with scan-out so both ends agree on layout.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_slot,
  output logic              o_in_range
);

  logic [9:0]        w_word;
  logic [ADDR_W-1:0] w_base;

  // Three pixels per word, fixed words per line.
  always_comb begin
    w_word     = i_x / 10'd3;
    w_base     = ADDR_W'(i_y) * ADDR_W'(WORDS_PER_LINE);
    o_addr     = w_base + ADDR_W'(w_word);
    o_slot     = 2'(i_x - w_word * 10'd3);
    o_in_range = (i_x < 10'(H_RES)) &&
                 (i_y < 10'(V_RES));
  end

endmodule

// File: rtl/vga_fb_writer.sv
// Frame-buffer write side: packs RGB333 pixels
// into 32-bit words, read-modify-writes partials.
module vga_fb_writer
  import fb_pkg::*;
(
  input  logic        clk25,
  input  logic        reset,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [8:0]  pix_rgb,
  input  logic        pix_last,
  output logic        sram_req,
  output logic        sram_we,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_gnt,
  input  logic [31:0] sram_rdata,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  fb_state_e         r_state;
  logic [ADDR_W-1:0] r_acc_addr;
  logic [DATA_W-1:0] r_acc_data;
  logic [2:0]        r_acc_mask;
  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [2:0]        r_pend_mask;
  logic              r_pend_last;
  logic              r_ready;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [15:0]       r_drop;

  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_slot;
  logic              w_in_range;
  logic              w_accept;
  logic              w_same;
  logic              w_hit;
  logic              w_miss;
  logic              w_flush;
  logic [DATA_W-1:0] w_pix_data;
  logic [2:0]        w_pix_mask;
  logic [DATA_W-1:0] w_pix_bits;
  logic [DATA_W-1:0] w_new_data;
  logic [2:0]        w_new_mask;
  logic              w_new_full;
  logic [31:0]       w_rmw;

  fb_addr_calc u_addr (
    .i_x        (pix_x),
    .i_y        (pix_y),
    .o_addr     (w_addr),
    .o_slot     (w_slot),
    .o_in_range (w_in_range)
  );

  assign pix_ready  = r_ready;
  assign sram_req   = r_req;
  assign sram_we    = r_we;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign drop_cnt   = r_drop;
  assign busy       = (r_state != ST_IDLE) || r_pend_v;

  // Incoming pixel placement, merge and flush decision.
  always_comb begin
    w_accept   = pix_valid && r_ready;
    w_same     = (w_addr == r_acc_addr);
    w_hit      = w_accept && w_in_range && w_same;
    w_miss     = w_accept && w_in_range && !w_same;
    w_pix_data = slot_place(pix_rgb, w_slot);
    w_pix_mask = slot_onehot(w_slot);
    w_pix_bits = {{PIX_W{w_pix_mask[2]}},
                  {PIX_W{w_pix_mask[1]}},
                  {PIX_W{w_pix_mask[0]}}};
    w_new_data = r_acc_data;
    w_new_mask = r_acc_mask;
    if (w_hit) begin
      w_new_data = (r_acc_data & ~w_pix_bits)
                 | w_pix_data;
      w_new_mask = r_acc_mask | w_pix_mask;
    end
    w_new_full = &w_new_mask;
    w_flush    = w_accept &&
                 (pix_last || w_new_full || w_miss);
  end

  // Slots we own keep new pixels; the rest come from SRAM.
  always_comb begin
    w_rmw = sram_rdata;
    for (int i = 0; i < 3; i++) begin
      if (r_acc_mask[i]) begin
        w_rmw[i*PIX_W +: PIX_W] =
          r_acc_data[i*PIX_W +: PIX_W];
      end
    end
    w_rmw[31:DATA_W] = '0;
  end

  // Saturating count of discarded out-of-range pixels.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      r_drop <= '0;
    end else if (w_accept && !w_in_range &&
                 r_drop != 16'hFFFF) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  // Accumulate, flush and SRAM request sequencing.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_acc_addr  <= '0;
      r_acc_data  <= '0;
      r_acc_mask  <= '0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_pend_mask <= '0;
      r_pend_last <= 1'b0;
      r_ready     <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept && w_in_range) begin
            r_acc_addr <= w_addr;
            r_acc_data <= w_pix_data;
            r_acc_mask <= w_pix_mask;
            if (pix_last) begin
              r_state <= ST_RD_REQ;
              r_ready <= 1'b0;
              r_req   <= 1'b1;
              r_we    <= 1'b0;
              r_addr  <= w_addr;
            end else begin
              r_state <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (w_hit) begin
            r_acc_data <= w_new_data;
            r_acc_mask <= w_new_mask;
          end
          if (w_miss) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= w_addr;
            r_pend_data <= w_pix_data;
            r_pend_mask <= w_pix_mask;
            r_pend_last <= pix_last;
          end
          if (w_flush) begin
            r_ready <= 1'b0;
            r_req   <= 1'b1;
            r_we    <= w_new_full;
            r_addr  <= r_acc_addr;
            r_wdata <= {5'b0, w_new_data};
            r_state <= w_new_full ? ST_WR_REQ
                                  : ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (sram_gnt) begin
            r_req   <= 1'b0;
            r_state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          r_acc_data <= w_rmw[DATA_W-1:0];
          r_wdata    <= w_rmw;
          r_req      <= 1'b1;
          r_we       <= 1'b1;
          r_state    <= ST_WR_REQ;
        end
        ST_WR_REQ: begin
          if (sram_gnt) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_pend_v) begin
              r_pend_v   <= 1'b0;
              r_acc_addr <= r_pend_addr;
              r_acc_data <= r_pend_data;
              r_acc_mask <= r_pend_mask;
              if (r_pend_last) begin
                r_req   <= 1'b1;
                r_addr  <= r_pend_addr;
                r_state <= ST_RD_REQ;
              end else begin
                r_ready <= 1'b1;
                r_state <= ST_ACC;
              end
            end else begin
              r_acc_mask <= '0;
              r_ready    <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Bench for vga_fb_writer: SRAM model plus
// a pixel-level image reference.
module tb_vga_fb_writer;

  logic        clk25 = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [8:0]  pix_rgb;
  logic        pix_last;
  logic        sram_req;
  logic        sram_we;
  logic [19:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_gnt;
  logic [31:0] sram_rdata;
  logic        busy;
  logic [15:0] drop_cnt;

  bit [31:0]   mem     [0:131071];
  bit [31:0]   ref_mem [0:131071];
  int          errs   = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [19:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [19:0] last_rd_addr;
  int          gnt_mode = 0;
  int          ref_drop = 0;

  always #5 clk25 = ~clk25;

  vga_fb_writer dut (
    .clk25      (clk25),
    .reset      (reset),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .pix_last   (pix_last),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_gnt   (sram_gnt),
    .sram_rdata (sram_rdata),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // SRAM: grant performs the access this cycle.
  always @(posedge clk25) begin
    if (sram_req === 1'b1 && sram_gnt === 1'b1) begin
      if (sram_we) begin
        mem[sram_addr[16:0]] = sram_wdata;
        wr_cnt++;
        last_wr_addr = sram_addr;
        last_wr_data = sram_wdata;
      end else begin
        sram_rdata <= mem[sram_addr[16:0]];
        rd_cnt++;
        last_rd_addr = sram_addr;
      end
    end
  end

  always @(negedge clk25) begin
    case (gnt_mode)
      0:       sram_gnt = 1'b1;
      1:       sram_gnt = ($urandom_range(0, 1) == 0);
      default: sram_gnt = 1'b0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk25);
      #1;
    end
  endtask

  task automatic model_pix(input int x, input int y,
                           input logic [8:0] rgb);
    int a;
    int s;
    bit [31:0] w;
    if (x < 640 && y < 480) begin
      a = y * 214 + x / 3;
      s = x % 3;
      w = ref_mem[a];
      w[31:27] = 5'b0;
      w[s*9 +: 9] = rgb;
      ref_mem[a] = w;
    end else if (ref_drop < 65535) begin
      ref_drop++;
    end
  endtask

  task automatic send_pix(input int x, input int y,
                          input logic [8:0] rgb,
                          input logic last);
    int n;
    logic rdy;
    n = 0;
    pix_valid = 1'b1;
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_rgb = rgb;
    pix_last = last;
    forever begin
      rdy = pix_ready;
      tick();
      if (rdy) begin
        model_pix(x, y, rgb);
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'(rdy), 32'(1));
        break;
      end
    end
    pix_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    int w0;
    int r0;
    int n;
    logic stable;
    logic [19:0] ha;
    logic [31:0] hd;
    int x;
    int y;
    int px;
    int base;

    reset = 1'b0;
    pix_valid = 1'b0;
    pix_x = '0;
    pix_y = '0;
    pix_rgb = '0;
    pix_last = 1'b0;
    sram_gnt = 1'b1;
    sram_rdata = '0;
    tick(3);

    check("rst_req", 32'(sram_req), 32'(0));
    check("rst_we", 32'(sram_we), 32'(0));
    check("rst_addr", 32'(sram_addr), 32'(0));
    check("rst_wdata", sram_wdata, 32'(0));
    check("rst_ready", 32'(pix_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_drop", 32'(drop_cnt), 32'(0));

    reset = 1'b1;
    tick();
    check("ready_rise", 32'(pix_ready), 32'(1));

    // full word, grant tied high
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_pix(0, 0, 9'h1FF, 1'b0);
    send_pix(1, 0, 9'h0AA, 1'b0);
    send_pix(2, 0, 9'h155, 1'b0);
    check("full_req_we", 32'({sram_req, sram_we}),
          32'(2'b11));
    check("full_ready_lo", 32'(pix_ready), 32'(0));
    tick();
    check("full_ready_hi", 32'(pix_ready), 32'(1));
    check("full_wr_n", 32'(wr_cnt - w0), 32'(1));
    check("full_rd_n", 32'(rd_cnt - r0), 32'(0));
    check("full_addr", 32'(last_wr_addr), 32'(0));
    check("full_data", last_wr_data,
          {5'b0, 9'h155, 9'h0AA, 9'h1FF});

    // single pixel with last, read-modify-write
    mem[214] = 32'h07FFFFFF;
    mem[215] = 32'h07FFFFFF;
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_pix(4, 1, 9'h03F, 1'b1);
    check("rmw_rd_req", 32'({sram_req, sram_we}),
          32'(2'b10));
    check("rmw_rd_addr", 32'(sram_addr), 32'(215));
    check("rmw_rdy_n1", 32'(pix_ready), 32'(0));
    tick();
    check("rmw_req_n2", 32'(sram_req), 32'(0));
    check("rmw_rdy_n2", 32'(pix_ready), 32'(0));
    tick();
    check("rmw_wr_req", 32'({sram_req, sram_we}),
          32'(2'b11));
    check("rmw_rdy_n3", 32'(pix_ready), 32'(0));
    tick();
    check("rmw_rdy_n4", 32'(pix_ready), 32'(1));
    check("rmw_rd_n", 32'(rd_cnt - r0), 32'(1));
    check("rmw_rd_at", 32'(last_rd_addr), 32'(215));
    check("rmw_wr_n", 32'(wr_cnt - w0), 32'(1));
    check("rmw_wr_at", 32'(last_wr_addr), 32'(215));
    check("rmw_data", last_wr_data,
          {5'b0, 9'h1FF, 9'h03F, 9'h1FF});

    // address change leaves a pending pixel
    w0 = wr_cnt;
    send_pix(0, 0, 9'h011, 1'b0);
    send_pix(3, 0, 9'h022, 1'b0);
    n = 0;
    while (!pix_ready && n < 20) begin
      n++;
      tick();
    end
    check("chg_gap", 32'(n), 32'(3));
    check("chg_busy", 32'(busy), 32'(1));
    check("chg_wr_at", 32'(last_wr_addr), 32'(0));
    check("chg_data", last_wr_data,
          {5'b0, 9'h155, 9'h0AA, 9'h011});
    send_pix(640, 0, 9'h000, 1'b1);
    wait_idle(50);
    check("chg_wr_n", 32'(wr_cnt - w0), 32'(2));
    check("chg_pend_at", 32'(last_wr_addr), 32'(1));
    check("chg_pend_data", last_wr_data,
          32'h00000022);
    check("chg_drop", 32'(drop_cnt), 32'(ref_drop));

    // dropped pixel alone touches no SRAM
    w0 = wr_cnt;
    r0 = rd_cnt;
    send_pix(640, 0, 9'h1AB, 1'b0);
    tick(3);
    check("drop_cnt", 32'(drop_cnt), 32'(ref_drop));
    check("drop_access", 32'((wr_cnt - w0) + (rd_cnt - r0)),
          32'(0));
    check("drop_req", 32'(sram_req), 32'(0));

    // write held off by grant
    gnt_mode = 2;
    w0 = wr_cnt;
    send_pix(6, 0, 9'h001, 1'b0);
    send_pix(7, 0, 9'h002, 1'b0);
    send_pix(8, 0, 9'h003, 1'b0);
    ha = sram_addr;
    hd = sram_wdata;
    stable = sram_req;
    repeat (10) begin
      tick();
      if (sram_req !== 1'b1 || sram_addr !== ha ||
          sram_wdata !== hd) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'(1));
    check("hold_no_wr", 32'(wr_cnt - w0), 32'(0));
    gnt_mode = 0;
    wait_idle(20);
    check("hold_wr_n", 32'(wr_cnt - w0), 32'(1));
    check("hold_addr", 32'(last_wr_addr), 32'(2));
    check("hold_data", last_wr_data,
          {5'b0, 9'h003, 9'h002, 9'h001});

    // reset during the read wait
    w0 = wr_cnt;
    send_pix(9, 0, 9'h005, 1'b1);
    tick();
    check("rw_state", 32'({sram_req, busy}),
          32'(2'b01));
    reset = 1'b0;
    tick();
    check("rw_req", 32'(sram_req), 32'(0));
    check("rw_we", 32'(sram_we), 32'(0));
    check("rw_addr", 32'(sram_addr), 32'(0));
    check("rw_wdata", sram_wdata, 32'(0));
    check("rw_ready", 32'(pix_ready), 32'(0));
    check("rw_busy", 32'(busy), 32'(0));
    check("rw_drop", 32'(drop_cnt), 32'(0));
    ref_drop = 0;
    tick(3);
    check("rw_no_wr", 32'(wr_cnt - w0), 32'(0));
    reset = 1'b1;
    tick();

    // random pixels, random grant latency
    base = 100 * 214;
    for (int a = base; a < base + 4 * 214; a++) begin
      mem[a] = $urandom;
      ref_mem[a] = mem[a];
    end
    gnt_mode = 1;
    px = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0)
        x = (px / 3) * 3 + $urandom_range(0, 2);
      else
        x = $urandom_range(0, 700);
      if ($urandom_range(0, 15) == 0)
        y = $urandom_range(480, 490);
      else
        y = $urandom_range(100, 103);
      px = (x < 640) ? x : 0;
      send_pix(x, y, 9'($urandom),
               ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0)
        tick($urandom_range(1, 3));
    end
    send_pix(640, 0, 9'h000, 1'b1);
    wait_idle(300);
    gnt_mode = 0;
    for (int a = base; a < base + 4 * 214; a++) begin
      check($sformatf("img_%0d", a), mem[a],
            ref_mem[a]);
    end
    check("rand_drop", 32'(drop_cnt), 32'(ref_drop));

    // drop counter saturation
    pix_valid = 1'b1;
    pix_x = 10'd640;
    pix_y = 10'd0;
    pix_last = 1'b0;
    repeat (65600) begin
      if (pix_ready && ref_drop < 65535) ref_drop++;
      tick();
    end
    pix_valid = 1'b0;
    tick();
    check("sat_model", 32'(drop_cnt), 32'(ref_drop));
    check("sat_value", 32'(drop_cnt), 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
